// File: rtl/memory_pattern_writer.sv
// Bus master that writes a packed pattern into an address window, reads it back
// and reports done, a sticky error flag and the index of the first bad word.
module memory_pattern_writer #(
  parameter int base_addr  = 0,
  parameter int addr_size  = 16,
  parameter int word_size  = 16,
  parameter int array_size = 1,
  parameter logic [array_size*word_size-1:0] array_content = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic [addr_size-1:0]          addr,
  output logic [word_size-1:0]          data_out,
  input  logic [word_size-1:0]          data_in,
  output logic                          write_en,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(array_size):0]   bad_index
);

  localparam int IW = $clog2(array_size + 1);
  localparam int BW = $clog2(array_size) + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;

  // Window addresses wrap modulo 2^addr_size by truncation.
  function automatic logic [addr_size-1:0] win_addr(input int k);
    return addr_size'(base_addr + k);
  endfunction

  function automatic logic [word_size-1:0] word_at(input int k);
    return word_size'(array_content >> (k * word_size));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      addr      <= '0;
      data_out  <= '0;
      write_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      bad_index <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= WRITE;
            idx       <= '0;
            addr      <= win_addr(0);
            data_out  <= word_at(0);
            write_en  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            bad_index <= '0;
          end
        end
        WRITE: begin
          if (int'(idx) == array_size - 1) begin
            state    <= READ;
            idx      <= '0;
            write_en <= 1'b0;
            addr     <= win_addr(0);
            data_out <= '0;
          end else begin
            idx      <= idx + 1'b1;
            addr     <= win_addr(int'(idx) + 1);
            data_out <= word_at(int'(idx) + 1);
          end
        end
        READ: begin
          // data_in now holds the word addressed one cycle earlier (index idx-1).
          if (idx != '0 && !error && data_in !== word_at(int'(idx) - 1)) begin
            error     <= 1'b1;
            bad_index <= BW'(int'(idx) - 1);
          end
          if (int'(idx) == array_size) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            addr  <= '0;
          end else begin
            idx  <= idx + 1'b1;
            addr <= (int'(idx) + 1 < array_size) ? win_addr(int'(idx) + 1) : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_pattern_writer.sv
// Directed bench: four writer instances (reset, nominal/fault, wrap, minimum size)
// each backed by a registered-read RAM model.
module tb_memory_pattern_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] start_v;
  logic       corrupt;

  // Instance 0: reset test, N=4
  logic [15:0] addr_r, dout_r;
  logic        we_r, busy_r, done_r, err_r;
  logic [2:0]  bi_r;
  // Instance 1: nominal / fault, base 16, N=3
  logic [15:0] addr_a, dout_a, din_a, rd_a, la_a;
  logic        we_a, busy_a, done_a, err_a;
  logic [2:0]  bi_a;
  // Instance 2: wrap, 4-bit address, base 14, N=3
  logic [3:0]  addr_w;
  logic [15:0] dout_w, rd_w;
  logic        we_w, busy_w, done_w, err_w;
  logic [2:0]  bi_w;
  // Instance 3: minimum size, base 5, N=1
  logic [15:0] addr_m, dout_m, rd_m;
  logic        we_m, busy_m, done_m, err_m;
  logic [0:0]  bi_m;

  memory_pattern_writer #(.base_addr(0), .addr_size(16), .word_size(16), .array_size(4),
    .array_content(64'h4444_3333_2222_1111)) dut_r (
    .clk(clk), .reset(reset), .start(start_v[0]), .addr(addr_r), .data_out(dout_r),
    .data_in(16'h0000), .write_en(we_r), .busy(busy_r), .done(done_r), .error(err_r),
    .bad_index(bi_r));

  memory_pattern_writer #(.base_addr(16), .addr_size(16), .word_size(16), .array_size(3),
    .array_content(48'hC0DE_BEEF_1234)) dut_a (
    .clk(clk), .reset(reset), .start(start_v[1]), .addr(addr_a), .data_out(dout_a),
    .data_in(din_a), .write_en(we_a), .busy(busy_a), .done(done_a), .error(err_a),
    .bad_index(bi_a));

  memory_pattern_writer #(.base_addr(14), .addr_size(4), .word_size(16), .array_size(3),
    .array_content(48'h0F0F_5555_AAAA)) dut_w (
    .clk(clk), .reset(reset), .start(start_v[2]), .addr(addr_w), .data_out(dout_w),
    .data_in(rd_w), .write_en(we_w), .busy(busy_w), .done(done_w), .error(err_w),
    .bad_index(bi_w));

  memory_pattern_writer #(.base_addr(5), .addr_size(16), .word_size(16), .array_size(1),
    .array_content(16'hA5A5)) dut_m (
    .clk(clk), .reset(reset), .start(start_v[3]), .addr(addr_m), .data_out(dout_m),
    .data_in(rd_m), .write_en(we_m), .busy(busy_m), .done(done_m), .error(err_m),
    .bad_index(bi_m));

  // RAM models: write on the edge, read data registered one cycle after addr.
  logic [15:0] mem_a [256];
  logic [15:0] mem_w [16];
  logic [15:0] mem_m [256];

  always @(posedge clk) begin
    if (we_a) mem_a[addr_a[7:0]] <= dout_a;
    rd_a <= mem_a[addr_a[7:0]];
    la_a <= addr_a;
    if (we_w) mem_w[addr_w] <= dout_w;
    rd_w <= mem_w[addr_w];
    if (we_m) mem_m[addr_m[7:0]] <= dout_m;
    rd_m <= mem_m[addr_m[7:0]];
  end

  // Fault injection zeroes the read data returned for words 1 and 2.
  assign din_a = (corrupt && (la_a == 16'd17 || la_a == 16'd18)) ? 16'h0000 : rd_a;

  wire [3:0] we_all   = {we_m, we_w, we_a, we_r};
  wire [3:0] busy_all = {busy_m, busy_w, busy_a, busy_r};
  wire [3:0] done_all = {done_m, done_w, done_a, done_r};
  wire [3:0] err_all  = {err_m, err_w, err_a, err_r};
  logic [15:0] addr_all [4];
  logic [15:0] dout_all [4];
  always_comb begin
    addr_all[0] = addr_r;  dout_all[0] = dout_r;
    addr_all[1] = addr_a;  dout_all[1] = dout_a;
    addr_all[2] = {12'h000, addr_w};  dout_all[2] = dout_w;
    addr_all[3] = addr_m;  dout_all[3] = dout_m;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int          dc, bc, nwr, err1, done1;
  logic [15:0] wa [8];
  logic [15:0] wd [8];
  int          wc [8];

  // Pulse start on instance d and log cycles until done; cycle 1 is the first after the start edge.
  task automatic run(input int d, input bit poke);
    start_v[d] = 1'b1;
    tick;
    start_v[d] = 1'b0;
    dc = 1; bc = 0; nwr = 0;
    err1 = int'(err_all[d]);
    done1 = int'(done_all[d]);
    while (!done_all[d] && dc < 40) begin
      if (busy_all[d]) bc++;
      if (we_all[d] && nwr < 8) begin
        wa[nwr] = addr_all[d];
        wd[nwr] = dout_all[d];
        wc[nwr] = dc;
        nwr++;
      end
      start_v[d] = poke && dc == 2;
      tick;
      dc++;
    end
    start_v[d] = 1'b0;
    if (dc >= 40) check("done_timeout", 32'(dc), 32'd0);
  endtask

  logic [15:0] exp_a [3] = '{16'h1234, 16'hBEEF, 16'hC0DE};
  logic [15:0] exp_w [3] = '{16'hAAAA, 16'h5555, 16'h0F0F};
  logic [15:0] adr_w [3] = '{16'd14, 16'd15, 16'd0};

  initial begin
    int n;
    reset = 1'b1; start_v = '0; corrupt = 1'b0;
    repeat (2) tick;
    reset = 1'b0;
    check("rst_bus_r", {addr_r, dout_r}, 32'h0);
    check("rst_ctl_r", 32'({we_r, busy_r, done_r, err_r, bi_r}), 32'h0);
    check("rst_ctl_a", 32'({we_a, busy_a, done_a, err_a, bi_a}), 32'h0);

    // Reset in the middle of a write sequence
    start_v[0] = 1'b1;
    tick;
    start_v[0] = 1'b0;
    check("r_wr0", {addr_r, dout_r}, 32'h0000_1111);
    check("r_we0", 32'(we_r), 32'd1);
    tick; tick;
    check("r_wr2", {addr_r, dout_r}, 32'h0002_3333);
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    check("r_abort_bus", {addr_r, dout_r}, 32'h0);
    check("r_abort_ctl", 32'({we_r, busy_r, done_r, err_r, bi_r}), 32'h0);
    n = 0;
    repeat (10) begin
      tick;
      if (we_r) n++;
    end
    check("r_idle_we", 32'(n), 32'd0);

    // Nominal load and readback
    run(1, 1'b0);
    check("a_nwr", 32'(nwr), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("a_wr%0d", i), {wa[i], wd[i]}, {16'(16 + i), exp_a[i]});
      check($sformatf("a_wcyc%0d", i), 32'(wc[i]), 32'(i + 1));
      check($sformatf("a_mem%0d", i), 32'(mem_a[16 + i]), 32'(exp_a[i]));
    end
    check("a_done_cyc", 32'(dc), 32'd8);
    check("a_busy", 32'(bc), 32'd7);
    check("a_err", 32'({err_a, bi_a}), 32'h0);

    // Corrupted readback of words 1 and 2; restart from DONE
    corrupt = 1'b1;
    run(1, 1'b0);
    corrupt = 1'b0;
    check("f_done_drop", 32'(done1), 32'd0);
    check("f_done_cyc", 32'(dc), 32'd8);
    check("f_err", 32'(err_a), 32'd1);
    check("f_bad_index", 32'(bi_a), 32'd1);

    // Restart with error cleared, start poked during WRITE
    run(1, 1'b1);
    check("p_err_clr", 32'(err1), 32'd0);
    check("p_nwr", 32'(nwr), 32'd3);
    check("p_busy", 32'(bc), 32'd7);
    check("p_done_cyc", 32'(dc), 32'd8);
    check("p_err", 32'({err_a, bi_a}), 32'h0);

    // Window wrapping past the top of a 4-bit address space
    run(2, 1'b0);
    check("w_nwr", 32'(nwr), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("w_wr%0d", i), {wa[i], wd[i]}, {adr_w[i], exp_w[i]});
    check("w_mem0", 32'(mem_w[0]), 32'h0F0F);
    check("w_done_cyc", 32'(dc), 32'd8);
    check("w_err", 32'({err_w, bi_w}), 32'h0);

    // Single-word window
    run(3, 1'b0);
    check("m_nwr", 32'(nwr), 32'd1);
    check("m_wr0", {wa[0], wd[0]}, 32'h0005_A5A5);
    check("m_done_cyc", 32'(dc), 32'd4);
    check("m_busy", 32'(bc), 32'd3);
    check("m_err", 32'({err_m, bi_m}), 32'h0);
    check("m_bus_idle", {addr_m, dout_m}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
